// File: rtl/rvfi_imem_learn_check.sv
// -----------------------------------------------------------------------------
// rvfi_imem_learn_check
//
// Instruction-memory consistency checker on the RVFI retirement bus. Each slot
// watches one halfword address. The first qualifying retirement that fetches
// that halfword stores its value. Every later retirement that fetches it must
// return the same value. Mismatches are reported through registered, sticky
// error outputs rather than inline assertions.
//
// Build option:
//   RVFI_IMEM_FENCEI_EN - when defined, a qualifying FENCE.I retirement empties
//                         every slot. Channels above the FENCE.I channel in the
//                         same cycle see empty slots and may relearn them.
//
// Ports:
//   clk, resetn    clock; synchronous active-low reset
//   slot_addr      NSLOT*XLEN watched halfword addresses (slot k at [k*XLEN +: XLEN]).
//                  An odd address disables that slot. Hold stable after reset.
//   rvfi_valid     NRET   retirement valid per channel
//   rvfi_insn      NRET*32 retired instruction word
//   rvfi_trap      NRET   retirement trapped
//   rvfi_pc_rdata  NRET*XLEN PC of the retired instruction
//   learned        NSLOT  per-slot state (1 = LEARNED, 0 = EMPTY)
//   err            sticky mismatch flag
//   err_slot/err_chan/err_expect/err_actual  capture of the first mismatch
//   check_cnt      saturating count of successful compares
//
// Handshake: rvfi_valid alone qualifies each channel in the cycle it is high.
// There is no ready signal, and the checker never back-pressures the core.
// -----------------------------------------------------------------------------
module rvfi_imem_learn_check #(
    parameter int XLEN        = 32,
    parameter int NRET        = 1,
    parameter int NSLOT       = 4,
    parameter int CNTW        = 16,
    parameter int IGNORE_TRAP = 1,
    localparam int SW         = (NSLOT > 1) ? $clog2(NSLOT) : 1,
    localparam int CHW        = (NRET > 1) ? $clog2(NRET) : 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NSLOT*XLEN-1:0]   slot_addr,
    input  logic [NRET-1:0]         rvfi_valid,
    input  logic [NRET*32-1:0]      rvfi_insn,
    input  logic [NRET-1:0]         rvfi_trap,
    input  logic [NRET*XLEN-1:0]    rvfi_pc_rdata,
    output logic [NSLOT-1:0]        learned,
    output logic                    err,
    output logic [SW-1:0]           err_slot,
    output logic [CHW-1:0]          err_chan,
    output logic [15:0]             err_expect,
    output logic [15:0]             err_actual,
    output logic [CNTW-1:0]         check_cnt
);

    // Width of the per-cycle match count, and of the saturating sum.
    localparam int MW   = $clog2(NRET*NSLOT + 1);
    localparam int SUMW = ((CNTW > MW) ? CNTW : MW) + 1;

    typedef enum logic {
        SLOT_EMPTY   = 1'b0,
        SLOT_LEARNED = 1'b1
    } slot_state_t;

    slot_state_t state     [NSLOT];
    logic [15:0] val       [NSLOT];
    slot_state_t nxt_state [NSLOT];
    logic [15:0] nxt_val   [NSLOT];

    logic [MW-1:0]   match_cnt;
    logic            mis_found;
    logic [SW-1:0]   mis_slot;
    logic [CHW-1:0]  mis_chan;
    logic [15:0]     mis_expect;
    logic [15:0]     mis_actual;

    logic [XLEN-1:0] pc_lo;
    logic [XLEN-1:0] pc_hi;
    logic [XLEN-1:0] addr;
    logic [31:0]     insn;
    logic            qual;
    logic            lo_hit;
    logic            hi_hit;
    logic [15:0]     hw;
    logic [SUMW-1:0] cnt_sum;

    // The learned output is the slot state itself.
    always_comb begin
        for (int k = 0; k < NSLOT; k++) begin
            learned[k] = (state[k] == SLOT_LEARNED);
        end
    end

    // Walk channels in ascending order, carrying the slot state forward. A
    // later channel therefore sees what an earlier channel learned (or what
    // a FENCE.I cleared) in the same cycle.
    always_comb begin
        for (int k = 0; k < NSLOT; k++) begin
            nxt_state[k] = state[k];
            nxt_val[k]   = val[k];
        end
        match_cnt  = '0;
        mis_found  = 1'b0;
        mis_slot   = '0;
        mis_chan   = '0;
        mis_expect = '0;
        mis_actual = '0;
        pc_lo      = '0;
        pc_hi      = '0;
        addr       = '0;
        insn       = '0;
        qual       = 1'b0;
        lo_hit     = 1'b0;
        hi_hit     = 1'b0;
        hw         = '0;

        for (int c = 0; c < NRET; c++) begin
            insn  = rvfi_insn[c*32 +: 32];
            pc_lo = rvfi_pc_rdata[c*XLEN +: XLEN];
            pc_hi = pc_lo + XLEN'(2);   // wraps at the top of the address space
            qual  = rvfi_valid[c] && !((IGNORE_TRAP != 0) && rvfi_trap[c]);

            for (int k = 0; k < NSLOT; k++) begin
                addr   = slot_addr[k*XLEN +: XLEN];
                // An odd slot address disables the slot.
                lo_hit = qual && !addr[0] && (pc_lo == addr);
                // Only a 32-bit instruction covers the following halfword.
                hi_hit = qual && !addr[0] && (insn[1:0] == 2'b11) && (pc_hi == addr);
                hw     = lo_hit ? insn[15:0] : insn[31:16];

                if (lo_hit || hi_hit) begin
                    if (nxt_state[k] == SLOT_EMPTY) begin
                        nxt_state[k] = SLOT_LEARNED;
                        nxt_val[k]   = hw;
                    end else if (nxt_val[k] == hw) begin
                        match_cnt = match_cnt + MW'(1);
                    end else if (!mis_found) begin
                        // The first mismatch in (channel, slot) order wins.
                        mis_found  = 1'b1;
                        mis_slot   = SW'(k);
                        mis_chan   = CHW'(c);
                        mis_expect = nxt_val[k];
                        mis_actual = hw;
                    end
                end
            end

`ifdef RVFI_IMEM_FENCEI_EN
            // FENCE.I clears the slots after its own fetch has been checked.
            if (qual && (insn[6:0] == 7'b0001111) && (insn[14:12] == 3'b001)) begin
                for (int k = 0; k < NSLOT; k++) begin
                    nxt_state[k] = SLOT_EMPTY;
                    nxt_val[k]   = '0;
                end
            end
`endif
        end

        cnt_sum = SUMW'(check_cnt) + SUMW'(match_cnt);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < NSLOT; k++) begin
                state[k] <= SLOT_EMPTY;
                val[k]   <= '0;
            end
            err        <= 1'b0;
            err_slot   <= '0;
            err_chan   <= '0;
            err_expect <= '0;
            err_actual <= '0;
            check_cnt  <= '0;
        end else begin
            for (int k = 0; k < NSLOT; k++) begin
                state[k] <= nxt_state[k];
                val[k]   <= nxt_val[k];
            end
            // Capture only the first mismatch after reset. The error stays set.
            if (!err && mis_found) begin
                err        <= 1'b1;
                err_slot   <= mis_slot;
                err_chan   <= mis_chan;
                err_expect <= mis_expect;
                err_actual <= mis_actual;
            end
            if (cnt_sum > SUMW'({CNTW{1'b1}})) begin
                check_cnt <= '1;
            end else begin
                check_cnt <= cnt_sum[CNTW-1:0];
            end
        end
    end

endmodule
